int_prio_unit: RTL and testbench
================================

# int_prio_unit

Interrupt priority unit that sits directly upstream of the fetch stage. It latches rising edges on peripheral interrupt lines and filters them through a mask register. It picks the lowest-numbered enabled pending source, raises `ipu_int` to fetch, and holds it until fetch acknowledges with `int_ack`. It then blocks further requests until the handler's return-from-interrupt is fetched (`int_ret`), so interrupts never nest.

## Interface
- `NUM_SRC`, default 4: number of interrupt sources; legal range 1..8.
- `ID_W`, default 2: width of `int_id`; must satisfy NUM_SRC <= 2**ID_W.

Ports:
- `clk`  in  1  — system clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `irq_in`  in  NUM_SRC  — raw interrupt lines, synchronous to `clk`; rising-edge sensitive.
- `mask_we`  in  1  — when high, load `mask_in` into the mask register.
- `mask_in`  in  NUM_SRC  — new mask value; bit = 1 enables that source.
- `int_ack`  in  1  — one-cycle pulse from fetch when it redirects to the handler.
- `int_ret`  in  1  — one-cycle pulse when a return-from-interrupt (opcode 4'b0011) is fetched.
- `ipu_int`  out  1  — registered interrupt request to fetch.
- `int_id`  out  ID_W  — index of the source being requested or serviced; readable by the handler.
- `pending`  out  NUM_SRC  — pending flags; masked sources are included.
- `busy`  out  1  — high while in the SERVICE state.

## Operation
- Edge detect:
  - `irq_prev` register holds `irq_in` from the previous cycle.
  - `rise = irq_in & ~irq_prev`.
  - `rise[i]` sets `pending[i]` at the clock edge.
- Mask:
  - Reset value is all ones.
  - A write never clears pending bits.
  - Masked pending bits remain set but are not eligible for selection.
- Eligible set is `pending & mask`. Selection is the lowest index among eligible bits (a fixed priority encoder).
- State machine, registered:
  - **IDLE**: if the eligible set is non-zero → REQ at the next edge; `int_id` <= encoder result; `ipu_int` <= 1.
  - **REQ**:
    - `ipu_int` stays 1 and `int_id` is frozen.
    - New higher-priority edges only set pending bits.
    - On `int_ack` → SERVICE at that edge: `ipu_int` <= 0 and `pending[int_id]` is cleared.
  - **SERVICE**:
    - `busy` = 1 and `ipu_int` = 0. `int_id` holds its value so the handler can read it.
    - On `int_ret` → IDLE.
- Simultaneous `rise[i]` and clear of `pending[i]` in the same cycle: the set wins, and the bit stays pending.
- If a mask write disables `int_id` while in REQ, the request is still completed; a mask change never cancels an issued request.
- Ignored inputs: `int_ack` outside REQ; `int_ret` outside SERVICE.
- Simultaneous `int_ack` and `int_ret` in REQ: only the ack is acted on.

## Timing
- Reset (`rst` low, asynchronous):
  - State = IDLE.
  - `ipu_int` = 0, `int_id` = 0, `pending` = 0, `busy` = 0.
  - `irq_prev` = 0, `mask` = all ones.
  - Outputs change immediately, not at a clock edge.
- Reset asserted mid-request or mid-service discards all pending state. Fetch is reset on the same net.
- Request latency, with `irq_in[i]` first sampled high at edge E:
  - `pending[i]` = 1 after E.
  - `ipu_int` = 1 after E+1, i.e. 2 edges.
- Handshake:
  - Fetch registers its acceptance, so `int_ack` arrives one cycle after fetch takes `ipu_int`.
  - `ipu_int` must stay high through that cycle and drop only on the edge that samples `int_ack`.
- Back-to-back:
  - `int_ret` at edge R → IDLE after R.
  - If the eligible set is non-zero, `ipu_int` rises again after R+1.
  - Minimum gap between services is 1 IDLE cycle.
- Mask write at edge W takes effect for selection after W.

## Test plan
- Reset and single source:
  - Hold `rst` low, then release; pulse `irq_in[2]` high.
  - Expect `pending` = 4'b0100 after E, then `ipu_int` = 1 and `int_id` = 2 after E+1.
  - `int_ack` pulse → `ipu_int` = 0, `busy` = 1, `pending` = 0.
  - `int_ret` → `busy` = 0.
- Priority:
  - Raise `irq_in[3]` and `irq_in[1]` at the same edge.
  - Expect `int_id` = 1 first.
  - After ack and ret, a second request with `int_id` = 3 occurs after 1 IDLE cycle.
- Mask:
  - Write `mask` = 4'b1110, then raise `irq_in[0]`.
  - Expect `pending[0]` = 1 and `ipu_int` stays 0.
  - Write `mask` = 4'b1111 → `ipu_int` = 1 with `int_id` = 0, two edges after the write.
- No nesting:
  - During SERVICE of source 2, raise `irq_in[0]`.
  - Expect `ipu_int` = 0 until `int_ret`, then `int_id` = 0.
  - A stray `int_ack` in SERVICE changes nothing.
- Set-wins and level hold:
  - Raise a new `irq_in[1]` edge in the same cycle as `int_ack` for `int_id` = 1.
  - Expect `pending[1]` to remain 1.
  - Holding `irq_in[1]` high afterwards produces no further pending set.
- Async reset mid-REQ:
  - Drop `rst` between edges while `ipu_int` = 1.
  - Expect `ipu_int` = 0, `pending` = 0, `mask` = 4'b1111 immediately, before the next clock edge.

Source files
------------

// File: rtl/int_prio_unit_if.sv
// Purpose: bundle of interrupt lines, mask write, fetch handshake and status for int_prio_unit.
// Latency: none (wires only).
// Backpressure: ipu_int is held until int_ack; int_ret reopens the unit for the next request.
// Ports: irq_in/mask_we/mask_in/int_ack/int_ret driven by master; ipu_int/int_id/pending/busy driven by slave.
interface int_prio_unit_if #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
);
  logic [NUM_SRC-1:0] irq_in;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_in;
  logic               int_ack;
  logic               int_ret;
  logic               ipu_int;
  logic [ID_W-1:0]    int_id;
  logic [NUM_SRC-1:0] pending;
  logic               busy;

  // Fetch/peripheral side.
  modport master (
    output irq_in, mask_we, mask_in, int_ack, int_ret,
    input  ipu_int, int_id, pending, busy
  );

  // Priority unit side.
  modport slave (
    input  irq_in, mask_we, mask_in, int_ack, int_ret,
    output ipu_int, int_id, pending, busy
  );
endinterface

// File: rtl/int_prio_unit.sv
// Purpose: edge-latching, maskable, fixed-priority interrupt requester for the fetch stage (no nesting).
// Latency: irq edge sampled at E -> pending after E -> ipu_int after E+1.
// Backpressure: ipu_int held until int_ack; no new request until int_ret ends the service.
// Ports: clk, rst (async active-low); bus (slave) carries irq_in, mask_we, mask_in, int_ack,
//        int_ret in and ipu_int, int_id, pending, busy out.
module int_prio_unit #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  int_prio_unit_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] irq_prev;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] mask_q;
  logic [ID_W-1:0]    int_id_q;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] id_onehot;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    sel_id;
  logic               sel_vld;
  logic               ack_take;

  assign rise     = bus.irq_in & ~irq_prev;
  assign eligible = pending_q & mask_q;
  assign sel_vld  = |eligible;
  // Ack only counts while a request is outstanding; stray acks are dropped.
  assign ack_take = (state_q == S_REQ) && bus.int_ack;

  // Fixed priority: scan from the top so the lowest eligible index wins.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = ID_W'(i);
    end
  end

  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      id_onehot[i] = (int_id_q == ID_W'(i));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (sel_vld)     state_d = S_REQ;
      S_REQ:     if (bus.int_ack) state_d = S_SERVICE;
      S_SERVICE: if (bus.int_ret) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Output logic. ipu_int/busy decode the state flops directly, so they are
  // glitch-free and clear asynchronously with reset like any registered output.
  always_comb begin
    bus.ipu_int = (state_q == S_REQ);
    bus.busy    = (state_q == S_SERVICE);
    clr         = ack_take ? id_onehot : '0;
  end

  // Datapath: edge history, pending flags, mask, serviced id.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_prev  <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      int_id_q  <= '0;
    end else begin
      irq_prev  <= bus.irq_in;
      // A new edge on the source being acked re-arms it: set beats clear.
      pending_q <= (pending_q & ~clr) | rise;
      if (bus.mask_we) mask_q <= bus.mask_in;
      // id is captured only when leaving IDLE and then frozen through REQ and SERVICE.
      if (state_q == S_IDLE && sel_vld) int_id_q <= sel_id;
    end
  end

  assign bus.int_id  = int_id_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_int_prio_unit.sv
// Purpose: self-checking bench for int_prio_unit: directed vectors, a spec-level model, literal pins.
// Latency: inputs driven on falling edges, DUT and model step on rising edges, compared on falling edges.
// Backpressure: fetch side modelled by directed int_ack/int_ret pulses.
module tb_int_prio_unit;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  int_prio_unit_if #(.NUM_SRC(N), .ID_W(IW)) bus ();

  int_prio_unit #(.NUM_SRC(N), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 = waiting, 1 = requesting fetch, 2 = handler running
  int       m_phase = 0;
  int       m_id    = 0;
  bit [N-1:0] m_pending = '0;
  bit [N-1:0] m_mask    = '1;
  bit [N-1:0] m_prev    = '0;

  always @(negedge rst) begin
    m_phase = 0; m_id = 0; m_pending = '0; m_mask = '1; m_prev = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      bit [N-1:0] edges;
      bit [N-1:0] nxt_pending;
      int         nxt_phase;
      int         nxt_id;
      edges       = bus.irq_in & ~m_prev;
      nxt_pending = m_pending;
      nxt_phase   = m_phase;
      nxt_id      = m_id;
      if (m_phase == 0) begin
        for (int i = N - 1; i >= 0; i--) begin
          if (m_pending[i] && m_mask[i]) begin
            nxt_id    = i;
            nxt_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (bus.int_ack) begin
          nxt_pending[m_id] = 1'b0;
          nxt_phase = 2;
        end
      end else begin
        if (bus.int_ret) nxt_phase = 0;
      end
      m_pending = nxt_pending | edges;
      m_phase   = nxt_phase;
      m_id      = nxt_id;
      m_prev    = bus.irq_in;
      if (bus.mask_we) m_mask = bus.mask_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_ipu_int", 32'(bus.ipu_int), 32'(m_phase == 1));
    chk("model_busy",    32'(bus.busy),    32'(m_phase == 2));
    chk("model_pending", 32'(bus.pending), 32'(m_pending));
    chk("model_int_id",  32'(bus.int_id),  32'(m_id));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ack_pulse();
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
  endtask

  task automatic ret_pulse();
    bus.int_ret = 1'b1; tick(); bus.int_ret = 1'b0;
  endtask

  initial begin
    bus.irq_in  = '0;
    bus.mask_we = 1'b0;
    bus.mask_in = '0;
    bus.int_ack = 1'b0;
    bus.int_ret = 1'b0;
    tick(); tick();
    chk("rst_ipu_int", 32'(bus.ipu_int), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_int_id",  32'(bus.int_id),  32'd0);
    rst = 1'b1;
    tick();

    // Single source 2.
    bus.irq_in = 4'b0100; tick();
    chk("t1_pending_after_E", 32'(bus.pending), 32'h4);
    chk("t1_ipu_after_E",     32'(bus.ipu_int), 32'd0);
    bus.irq_in = 4'b0000; tick();
    chk("t1_ipu_after_E1", 32'(bus.ipu_int), 32'd1);
    chk("t1_id",           32'(bus.int_id),  32'd2);
    tick();
    chk("t1_ipu_held", 32'(bus.ipu_int), 32'd1);
    ack_pulse();
    chk("t1_ack_ipu",     32'(bus.ipu_int), 32'd0);
    chk("t1_ack_busy",    32'(bus.busy),    32'd1);
    chk("t1_ack_pending", 32'(bus.pending), 32'd0);
    tick();
    ret_pulse();
    chk("t1_ret_busy", 32'(bus.busy), 32'd0);
    tick();

    // Priority: sources 3 and 1 together.
    bus.irq_in = 4'b1010; tick();
    tick();
    chk("t2_id_first", 32'(bus.int_id),  32'd1);
    chk("t2_ipu",      32'(bus.ipu_int), 32'd1);
    bus.irq_in = 4'b0000;
    ack_pulse();
    chk("t2_pending_left", 32'(bus.pending), 32'h8);
    ret_pulse();
    chk("t2_idle_gap", 32'(bus.ipu_int), 32'd0);
    tick();
    chk("t2_second_ipu", 32'(bus.ipu_int), 32'd1);
    chk("t2_second_id",  32'(bus.int_id),  32'd3);
    ack_pulse();
    ret_pulse();
    tick();

    // Mask.
    bus.mask_we = 1'b1; bus.mask_in = 4'b1110; tick();
    bus.mask_we = 1'b0;
    bus.irq_in = 4'b0001; tick();
    bus.irq_in = 4'b0000; tick(); tick();
    chk("t3_masked_pending", 32'(bus.pending), 32'h1);
    chk("t3_masked_ipu",     32'(bus.ipu_int), 32'd0);
    bus.mask_we = 1'b1; bus.mask_in = 4'b1111; tick();
    bus.mask_we = 1'b0;
    chk("t3_ipu_after_W", 32'(bus.ipu_int), 32'd0);
    tick();
    chk("t3_ipu_after_W1", 32'(bus.ipu_int), 32'd1);
    chk("t3_id",           32'(bus.int_id),  32'd0);
    ack_pulse();
    ret_pulse();
    tick();

    // No nesting.
    bus.irq_in = 4'b0100; tick();
    bus.irq_in = 4'b0000; tick();
    ack_pulse();
    bus.irq_in = 4'b0001; tick();
    bus.irq_in = 4'b0000; tick(); tick();
    chk("t4_no_nest_ipu", 32'(bus.ipu_int), 32'd0);
    chk("t4_busy",        32'(bus.busy),    32'd1);
    ack_pulse();
    chk("t4_stray_ack_busy", 32'(bus.busy),    32'd1);
    chk("t4_stray_ack_id",   32'(bus.int_id),  32'd2);
    chk("t4_stray_ack_pend", 32'(bus.pending), 32'h1);
    ret_pulse();
    tick();
    chk("t4_next_id",  32'(bus.int_id),  32'd0);
    chk("t4_next_ipu", 32'(bus.ipu_int), 32'd1);
    ack_pulse();
    ret_pulse();
    tick();

    // Set wins over clear, then level hold produces nothing new.
    bus.irq_in = 4'b0010; tick();
    bus.irq_in = 4'b0000; tick();
    chk("t5_id", 32'(bus.int_id), 32'd1);
    bus.irq_in = 4'b0010;
    ack_pulse();
    chk("t5_set_wins", 32'(bus.pending), 32'h2);
    tick();
    ret_pulse();
    tick();
    chk("t5_rerequest", 32'(bus.ipu_int), 32'd1);
    // Ack and ret together in REQ: only the ack acts.
    bus.int_ret = 1'b1;
    ack_pulse();
    bus.int_ret = 1'b0;
    chk("t5_ackret_busy", 32'(bus.busy), 32'd1);
    tick(); tick();
    chk("t5_level_hold", 32'(bus.pending), 32'h0);
    bus.irq_in = 4'b0000;
    ret_pulse();
    tick();

    // Async reset mid-request, mask restored to all ones.
    bus.mask_we = 1'b1; bus.mask_in = 4'b1101; tick();
    bus.mask_we = 1'b0;
    bus.irq_in = 4'b0001; tick();
    bus.irq_in = 4'b0000; tick();
    chk("t6_req_before_rst", 32'(bus.ipu_int), 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("t6_async_ipu",     32'(bus.ipu_int), 32'd0);
    chk("t6_async_pending", 32'(bus.pending), 32'd0);
    chk("t6_async_busy",    32'(bus.busy),    32'd0);
    tick();
    rst = 1'b1;
    tick();
    bus.irq_in = 4'b0010; tick();
    bus.irq_in = 4'b0000; tick();
    chk("t6_mask_reset_ipu", 32'(bus.ipu_int), 32'd1);
    chk("t6_mask_reset_id",  32'(bus.int_id),  32'd1);
    ack_pulse();
    ret_pulse();
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
